// File: rtl/mprj_wb_pkg.sv
// Shared types and defaults for the user-project Wishbone bridge.
package mprj_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    localparam logic [31:0] DEF_WIN_BASE = 32'h3000_0000;
    localparam logic [31:0] DEF_WIN_MASK = 32'hF000_0000;
    localparam logic [31:0] DEF_TO_DATA  = 32'hDEAD_BEEF;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mprj_wb_timeout.sv
// Ack-wait counter: cleared while idle, counts while enabled, saturates at
// TIMEOUT and flags expiry when it gets there.
module mprj_wb_timeout
    import mprj_wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Clear has priority; otherwise count up while enabled, holding at TMAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TMAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == TMAX);

endmodule

// File: rtl/mprj_wb_bridge.sv
// Splits one upstream Wishbone-classic window into NCH user-project channels
// with registered downstream requests, an ack timeout and sticky timeout status.
module mprj_wb_bridge
    import mprj_wb_pkg::*;
#(
    parameter int             NCH      = 2,
    parameter int             DW       = 32,
    parameter int             AW       = 32,
    parameter logic [AW-1:0]  WIN_BASE = AW'(DEF_WIN_BASE),
    parameter logic [AW-1:0]  WIN_MASK = AW'(DEF_WIN_MASK),
    parameter int             SEL_LSB  = 24,
    parameter int             TIMEOUT  = 255,
    parameter int             TO_ERR   = 0,
    parameter logic [DW-1:0]  TO_DATA  = DW'(DEF_TO_DATA)
) (
    input  logic                core_clk,
    input  logic                core_rstn,
    input  logic                bridge_en,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [DW/8-1:0]     wbs_sel_i,
    input  logic [AW-1:0]       wbs_adr_i,
    input  logic [DW-1:0]       wbs_dat_i,
    output logic                wbs_ack_o,
    output logic                wbs_err_o,
    output logic [DW-1:0]       wbs_dat_o,
    output logic                mprj_wb_iena,
    output logic [NCH-1:0]      mprj_cyc_o,
    output logic [NCH-1:0]      mprj_stb_o,
    output logic                mprj_we_o,
    output logic [DW/8-1:0]     mprj_sel_o,
    output logic [AW-1:0]       mprj_adr_o,
    output logic [DW-1:0]       mprj_dat_o,
    input  logic [NCH-1:0]      mprj_ack_i,
    input  logic [NCH*DW-1:0]   mprj_dat_i,
    input  logic                to_clr,
    output logic                to_flag,
    output logic [2:0]          to_ch
);

    localparam int              CHW      = (NCH > 1) ? clog2(NCH) : 1;
    localparam logic [CHW:0]    NCH_V    = (CHW + 1)'(NCH);
    // Completion used for both a timeout and an out-of-range channel index.
    localparam logic            TO_ACK   = (TO_ERR == 0);
    localparam logic [DW-1:0]   TO_RDATA = (TO_ERR == 0) ? TO_DATA : '0;

    state_e          state;
    logic [CHW-1:0]  ch_idx;
    logic [CHW-1:0]  ch_q;
    logic [NCH-1:0]  ch_onehot;
    logic            hit;
    logic            idx_ok;
    logic            ack_sel;
    logic [DW-1:0]   dat_sel;
    logic            expire;

    assign hit    = bridge_en & wbs_cyc_i & wbs_stb_i &
                    ((wbs_adr_i & WIN_MASK) == WIN_BASE);
    assign ch_idx = wbs_adr_i[SEL_LSB +: CHW];
    assign idx_ok = ({1'b0, ch_idx} < NCH_V);

    // Decode the requested channel and mux the return path of the latched one.
    always_comb begin
        ch_onehot = '0;
        ack_sel   = 1'b0;
        dat_sel   = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_onehot[c] = (ch_idx == CHW'(c));
            if (ch_q == CHW'(c)) begin
                ack_sel = mprj_ack_i[c];
                dat_sel = mprj_dat_i[c*DW +: DW];
            end
        end
    end

    mprj_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (core_clk),
        .rst_n  (core_rstn),
        .clr    (state != REQ),
        .en     (state == REQ),
        .expire (expire)
    );

    // Transaction FSM with all upstream/downstream outputs registered.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state      <= IDLE;
            ch_q       <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            wbs_dat_o  <= '0;
            mprj_cyc_o <= '0;
            mprj_stb_o <= '0;
            mprj_we_o  <= 1'b0;
            mprj_sel_o <= '0;
            mprj_adr_o <= '0;
            mprj_dat_o <= '0;
            to_flag    <= 1'b0;
            to_ch      <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (to_clr) to_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit && idx_ok) begin
                        ch_q       <= ch_idx;
                        mprj_cyc_o <= ch_onehot;
                        mprj_stb_o <= ch_onehot;
                        mprj_we_o  <= wbs_we_i;
                        mprj_sel_o <= wbs_sel_i;
                        mprj_adr_o <= wbs_adr_i;
                        mprj_dat_o <= wbs_dat_i;
                        state      <= REQ;
                    end else if (hit) begin
                        wbs_ack_o <= TO_ACK;
                        wbs_err_o <= !TO_ACK;
                        wbs_dat_o <= TO_RDATA;
                        state     <= RESP;
                    end
                end
                REQ: begin
                    if (!wbs_cyc_i) begin
                        mprj_cyc_o <= '0;
                        mprj_stb_o <= '0;
                        state      <= IDLE;
                    end else if (ack_sel) begin
                        mprj_cyc_o <= '0;
                        mprj_stb_o <= '0;
                        wbs_ack_o  <= 1'b1;
                        wbs_dat_o  <= dat_sel;
                        state      <= RESP;
                    end else if (expire) begin
                        mprj_cyc_o <= '0;
                        mprj_stb_o <= '0;
                        wbs_ack_o  <= TO_ACK;
                        wbs_err_o  <= !TO_ACK;
                        wbs_dat_o  <= TO_RDATA;
                        to_flag    <= 1'b1;
                        to_ch      <= 3'(ch_q);
                        state      <= RESP;
                    end
                end
                RESP: begin
                    wbs_dat_o <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return-path enable seen by the user side lags bridge_en by one cycle.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            mprj_wb_iena <= 1'b0;
        end else begin
            mprj_wb_iena <= bridge_en;
        end
    end

endmodule

// File: tb/tb_mprj_wb_bridge.sv
// Directed bench for mprj_wb_bridge: two instances (ack-style and err-style
// timeout completion) driven by the same master and slave model.
module tb_mprj_wb_bridge;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TO  = 15;

    logic              core_clk  = 1'b0;
    logic              core_rstn = 1'b1;
    logic              bridge_en = 1'b1;
    logic              wbs_cyc_i = 1'b0;
    logic              wbs_stb_i = 1'b0;
    logic              wbs_we_i  = 1'b0;
    logic [3:0]        wbs_sel_i = '0;
    logic [AW-1:0]     wbs_adr_i = '0;
    logic [DW-1:0]     wbs_dat_i = '0;
    logic              to_clr    = 1'b0;
    logic [NCH-1:0]    mprj_ack_i = '0;
    logic [NCH*DW-1:0] mprj_dat_i;

    logic              wbs_ack_o, wbs_err_o, mprj_wb_iena, mprj_we_o, to_flag;
    logic [DW-1:0]     wbs_dat_o, mprj_dat_o;
    logic [AW-1:0]     mprj_adr_o;
    logic [3:0]        mprj_sel_o;
    logic [NCH-1:0]    mprj_cyc_o, mprj_stb_o;
    logic [2:0]        to_ch;

    logic              e_ack, e_err, e_iena, e_we, e_to_flag;
    logic [DW-1:0]     e_dat, e_wdat;
    logic [AW-1:0]     e_adr;
    logic [3:0]        e_sel;
    logic [NCH-1:0]    e_cyc, e_stb;
    logic [2:0]        e_to_ch;

    mprj_wb_bridge #(.NCH(NCH), .TIMEOUT(TO), .TO_ERR(0)) u_dut (
        .core_clk(core_clk), .core_rstn(core_rstn), .bridge_en(bridge_en),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
        .mprj_wb_iena(mprj_wb_iena), .mprj_cyc_o(mprj_cyc_o), .mprj_stb_o(mprj_stb_o),
        .mprj_we_o(mprj_we_o), .mprj_sel_o(mprj_sel_o), .mprj_adr_o(mprj_adr_o),
        .mprj_dat_o(mprj_dat_o), .mprj_ack_i(mprj_ack_i), .mprj_dat_i(mprj_dat_i),
        .to_clr(to_clr), .to_flag(to_flag), .to_ch(to_ch)
    );

    mprj_wb_bridge #(.NCH(NCH), .TIMEOUT(TO), .TO_ERR(1)) u_dut_err (
        .core_clk(core_clk), .core_rstn(core_rstn), .bridge_en(bridge_en),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(e_ack), .wbs_err_o(e_err), .wbs_dat_o(e_dat),
        .mprj_wb_iena(e_iena), .mprj_cyc_o(e_cyc), .mprj_stb_o(e_stb),
        .mprj_we_o(e_we), .mprj_sel_o(e_sel), .mprj_adr_o(e_adr),
        .mprj_dat_o(e_wdat), .mprj_ack_i(mprj_ack_i), .mprj_dat_i(mprj_dat_i),
        .to_clr(to_clr), .to_flag(e_to_flag), .to_ch(e_to_ch)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc_cnt = 0;
    int          t0      = 0;
    int          lat     [NCH] = '{default: 0};
    logic [31:0] rdata   [NCH] = '{default: 32'h0};
    int          scnt    [NCH] = '{default: 0};
    int          stb_cnt [NCH] = '{default: 0};
    int          stb_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int stb_sum();
        return stb_cnt[0] + stb_cnt[1] + stb_cnt[2];
    endfunction

    always @(posedge core_clk) cyc_cnt <= cyc_cnt + 1;

    always_comb begin
        mprj_dat_i = '0;
        for (int c = 0; c < NCH; c++) mprj_dat_i[c*DW +: DW] = rdata[c];
    end

    // Slave model: channel c acks in the lat[c]-th cycle of its strobe (0 = never).
    always @(negedge core_clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (mprj_stb_o[c] && !mprj_ack_i[c]) begin
                scnt[c]       <= scnt[c] + 1;
                mprj_ack_i[c] <= ((scnt[c] + 1) == lat[c]);
            end else begin
                scnt[c]       <= 0;
                mprj_ack_i[c] <= 1'b0;
            end
        end
    end

    // Response monitor: every upstream ack/err must match the head of the scoreboard.
    always @(negedge core_clk) begin
        exp_t e;
        for (int c = 0; c < NCH; c++) if (mprj_stb_o[c]) stb_cnt[c] <= stb_cnt[c] + 1;
        if (wbs_ack_o || wbs_err_o) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'({wbs_ack_o, wbs_err_o}), 32'h0);
            end else begin
                e = sb.pop_front();
                check("resp_ack", 32'(wbs_ack_o), 32'(e.ack));
                check("resp_err", 32'(wbs_err_o), 32'(e.err));
                check("resp_dat", wbs_dat_o, e.dat);
                check("resp_cycle", cyc_cnt, e.cyc);
            end
        end
    end

    task automatic start_req(input logic [31:0] adr, input logic we,
                             input logic [31:0] dat, input logic [3:0] sel);
        @(negedge core_clk);
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        t0 = cyc_cnt + 1;
    endtask

    task automatic expect_resp(input logic ack, input logic err, input logic [31:0] dat, input int l);
        exp_t e;
        e.ack = ack;
        e.err = err;
        e.dat = dat;
        e.cyc = t0 + l;
        sb.push_back(e);
    endtask

    task automatic wait_resp(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge core_clk);
            n++;
        end while (!(wbs_ack_o || wbs_err_o) && n < budget);
        check("resp_seen", 32'(wbs_ack_o | wbs_err_o), 32'h1);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2 core_rstn = 1'b0;
        repeat (3) @(negedge core_clk);
        check("rst_ctl", 32'({wbs_ack_o, wbs_err_o, mprj_wb_iena, to_flag, to_ch, mprj_cyc_o,
                              mprj_stb_o, mprj_we_o, e_ack, e_err, e_iena, e_to_flag, e_to_ch,
                              e_cyc, e_stb, e_we}), 32'h0);
        check("rst_bus", wbs_dat_o | mprj_adr_o | mprj_dat_o | e_dat | e_adr | e_wdat, 32'h0);
        check("rst_sel", 32'({mprj_sel_o, e_sel}), 32'h0);
        core_rstn = 1'b1;
        @(negedge core_clk);
        check("iena_on", 32'(mprj_wb_iena), 32'h1);

        // Read ch1, one-cycle slave
        rdata[1] = 32'h1234_5678;
        lat[1]   = 1;
        start_req(32'h3100_0004, 1'b0, 32'h0, 4'hF);
        expect_resp(1'b1, 1'b0, 32'h1234_5678, 1);
        @(negedge core_clk);
        check("rd_stb", 32'(mprj_stb_o), 32'h2);
        check("rd_cyc", 32'(mprj_cyc_o), 32'h2);
        check("rd_adr", mprj_adr_o, 32'h3100_0004);
        check("rd_we", 32'(mprj_we_o), 32'h0);
        wait_resp(4);

        // Write ch0, slave acks in its fifth strobe cycle
        rdata[0] = 32'h5555_0000;
        lat[0]   = 5;
        stb_base = stb_cnt[1];
        start_req(32'h3000_0010, 1'b1, 32'hA5A5_A5A5, 4'b0011);
        expect_resp(1'b1, 1'b0, 32'h5555_0000, 5);
        @(negedge core_clk);
        check("wr_dat", mprj_dat_o, 32'hA5A5_A5A5);
        check("wr_sel", 32'(mprj_sel_o), 32'h3);
        check("wr_we", 32'(mprj_we_o), 32'h1);
        wait_resp(8);
        @(negedge core_clk);
        check("wr_single_ack", 32'({wbs_ack_o, wbs_err_o}), 32'h0);
        check("wr_ch1_quiet", stb_cnt[1] - stb_base, 32'h0);

        // Timeout on ch0, then clear the sticky flag
        lat[0] = 0;
        start_req(32'h3000_0020, 1'b0, 32'h0, 4'hF);
        expect_resp(1'b1, 1'b0, 32'hDEAD_BEEF, TO + 1);
        wait_resp(TO + 5);
        check("to_err_inst", 32'({e_ack, e_err}), 32'h1);
        check("to_err_dat", e_dat, 32'h0);
        check("to_flag_set", 32'(to_flag), 32'h1);
        check("to_ch0", 32'(to_ch), 32'h0);
        @(negedge core_clk);
        to_clr = 1'b1;
        @(negedge core_clk);
        to_clr = 1'b0;
        check("to_flag_clr", 32'(to_flag), 32'h0);

        // Out-of-range channel index completes at once with no downstream strobe
        stb_base = stb_sum();
        start_req(32'h3300_0000, 1'b0, 32'h0, 4'hF);
        expect_resp(1'b1, 1'b0, 32'hDEAD_BEEF, 0);
        wait_resp(3);
        check("bad_idx_err_inst", 32'({e_ack, e_err}), 32'h1);
        check("bad_idx_flag", 32'(to_flag), 32'h0);
        @(negedge core_clk);
        check("bad_idx_no_stb", stb_sum() - stb_base, 32'h0);

        // Address outside the window: bridge stays silent
        stb_base = stb_sum();
        start_req(32'h2000_0000, 1'b0, 32'h0, 4'hF);
        repeat (6) @(negedge core_clk);
        check("miss_no_resp", 32'({wbs_ack_o, wbs_err_o, e_ack, e_err}), 32'h0);
        check("miss_no_stb", stb_sum() - stb_base, 32'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;

        // Upstream abort three cycles into REQ
        start_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
        repeat (3) @(negedge core_clk);
        check("abort_stb_before", 32'(mprj_stb_o), 32'h1);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge core_clk);
        check("abort_drop", 32'({mprj_cyc_o, mprj_stb_o}), 32'h0);
        repeat (TO + 4) @(negedge core_clk);
        check("abort_no_flag", 32'(to_flag), 32'h0);

        // Ack in the same cycle the counter reaches TIMEOUT: ack wins
        rdata[0] = 32'h0BAD_F00D;
        lat[0]   = TO + 1;
        start_req(32'h3000_0040, 1'b0, 32'h0, 4'hF);
        expect_resp(1'b1, 1'b0, 32'h0BAD_F00D, TO + 1);
        wait_resp(TO + 5);
        check("race_err_inst", 32'({e_ack, e_err}), 32'h2);
        check("race_no_flag", 32'(to_flag), 32'h0);

        // Timeout on ch2 with to_clr asserted on the expiry cycle: set wins
        lat[2] = 0;
        start_req(32'h3200_0008, 1'b0, 32'h0, 4'hF);
        expect_resp(1'b1, 1'b0, 32'hDEAD_BEEF, TO + 1);
        repeat (TO + 1) @(negedge core_clk);
        to_clr = 1'b1;
        wait_resp(4);
        to_clr = 1'b0;
        check("set_beats_clr", 32'(to_flag), 32'h1);
        check("to_ch2", 32'(to_ch), 32'h2);

        // bridge_en low: iena follows one cycle later and hits are ignored
        @(negedge core_clk);
        bridge_en = 1'b0;
        @(negedge core_clk);
        check("iena_off", 32'(mprj_wb_iena), 32'h0);
        stb_base = stb_sum();
        start_req(32'h3100_0000, 1'b0, 32'h0, 4'hF);
        repeat (4) @(negedge core_clk);
        check("dis_no_stb", stb_sum() - stb_base, 32'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        bridge_en = 1'b1;

        // Asynchronous reset in the middle of REQ
        start_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
        @(negedge core_clk);
        check("mid_stb_before", 32'(mprj_stb_o), 32'h1);
        #2 core_rstn = 1'b0;
        #1;
        check("mid_rst_ctl", 32'({mprj_cyc_o, mprj_stb_o, to_flag, to_ch, wbs_ack_o, wbs_err_o}), 32'h0);
        check("mid_rst_bus", mprj_adr_o | wbs_dat_o, 32'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge core_clk);
        core_rstn = 1'b1;
        repeat (3) @(negedge core_clk);
        check("sb_drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
